// File: rtl/arb_pkg.sv
// Shared arbiter/queue definitions: requester id type and grant legality helper.
// Pure declarations, no timing or flow control of its own.
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int ID_W  = $clog2(N_REQ);

  typedef logic [ID_W-1:0] id_t;

  // True when at most one bit is set; callers zero-extend narrower vectors.
  function automatic logic onehot0(input logic [31:0] vec);
    return (vec & (vec - 32'd1)) == 32'd0;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; read data is the current head (no read latency).
// Push when full and pop when empty are ignored, so callers may drive them unguarded.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [W-1:0]           push_dat_i,
  input  logic                   pop_i,
  output logic [W-1:0]           pop_dat_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign pop_dat_o = mem[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    // Push and pop together leave the count untouched.
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/arb_req_queue.sv
// Per-requester ingress queues ahead of the arbiter; grant seen at edge g pops and drives out_* after g.
// No downstream backpressure; in_ready drops only when a queue is full (pushes then dropped).
module arb_req_queue
  import arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         in_valid,
  input  logic [N*W-1:0]       in_data,
  output logic [N-1:0]         in_ready,
  output logic [N-1:0]         req,
  input  logic [N-1:0]         grant,
  output logic                 out_valid,
  output logic [$clog2(N)-1:0] out_id,
  output logic [W-1:0]         out_data,
  output logic                 grant_err
);

  localparam int IDW = $clog2(N);
  localparam int CW  = $clog2(DEPTH) + 1;

  logic [W-1:0]  head [N];
  logic [CW-1:0] cnt  [N];
  logic [N-1:0]  full, empty, push, pop;
  logic          grant_legal;

  logic           out_valid_q, out_valid_d;
  logic [IDW-1:0] out_id_q, out_id_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic           grant_err_q, grant_err_d;

  assign grant_legal = onehot0(32'(grant));

  for (genvar i = 0; i < N; i++) begin : g_q
    assign in_ready[i] = ~full[i];
    assign push[i]     = in_valid[i] & ~full[i];
    assign pop[i]      = grant[i] & grant_legal & ~empty[i];
    // A sole entry already granted this cycle is claimed, so it stops requesting.
    assign req[i]      = (cnt[i] >= CW'(2)) | ((cnt[i] == CW'(1)) & ~grant[i]);

    sync_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (reset),
      .push_i    (push[i]),
      .push_dat_i(in_data[i*W +: W]),
      .pop_i     (pop[i]),
      .pop_dat_o (head[i]),
      .count_o   (cnt[i]),
      .full_o    (full[i]),
      .empty_o   (empty[i])
    );
  end

  always_comb begin
    out_valid_d = |pop;
    out_id_d    = out_id_q;
    out_data_d  = out_data_q;
    grant_err_d = grant_err_q | ~grant_legal;
    for (int i = 0; i < N; i++) begin
      if (pop[i]) begin
        out_id_d   = IDW'(i);
        out_data_d = head[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_data_q  <= '0;
      grant_err_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_data_q  <= out_data_d;
      grant_err_q <= grant_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_data  = out_data_q;
  assign grant_err = grant_err_q;

endmodule
